// File: rtl/digital_tube_avalon_master.sv
// rtl/digital_tube_avalon_master.sv - Avalon-MM initiator that programs the six-digit display controller
// Optional readback verification of the value register: define DT_MASTER_READBACK_EN.
module digital_tube_avalon_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_num,
    input  logic        req_enable,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        avm_address,
    output logic        avm_write,
    output logic        avm_read,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    localparam logic [19:0] MAX_NUM = 20'd999999;
    localparam logic [15:0] TMO     = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_NUM,
        WR_EN,
`ifdef DT_MASTER_READBACK_EN
        RD_NUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state_q;
    logic [19:0] num_q;
    logic        en_q;
    logic [15:0] wait_cnt_q;
    logic        req_ready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [19:0] num_sat_d;
    logic        timeout_d;
    logic        bus_active_d;

    assign num_sat_d = (req_num > MAX_NUM) ? MAX_NUM : req_num;
    assign timeout_d = (wait_cnt_q == TMO);

`ifdef DT_MASTER_READBACK_EN
    logic read_q;
    assign bus_active_d = write_q | read_q;
    assign avm_read     = read_q;
`else
    logic unused_readdata;
    assign bus_active_d    = write_q;
    assign avm_read        = 1'b0;
    assign unused_readdata = ^avm_readdata;
`endif

    // Strobes are only ever high in a bus state, so they double as the stall qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            en_q        <= 1'b0;
            wait_cnt_q  <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            addr_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
`ifdef DT_MASTER_READBACK_EN
            read_q      <= 1'b0;
`endif
        end else if (bus_active_d && avm_waitrequest) begin
            if (timeout_d) begin
                state_q <= ERR;
                write_q <= 1'b0;
`ifdef DT_MASTER_READBACK_EN
                read_q  <= 1'b0;
`endif
                done_q  <= 1'b1;
                error_q <= 1'b1;
            end else begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
        end else begin
            wait_cnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q     <= WR_NUM;
                        num_q       <= num_sat_d;
                        en_q        <= req_enable;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= 1'b0;
                        write_q     <= 1'b1;
                        wdata_q     <= {12'd0, num_sat_d};
                    end
                end
                WR_NUM: begin
                    state_q <= WR_EN;
                    addr_q  <= 1'b1;
                    wdata_q <= {31'd0, en_q};
                end
                WR_EN: begin
                    write_q <= 1'b0;
                    addr_q  <= 1'b0;
                    wdata_q <= '0;
`ifdef DT_MASTER_READBACK_EN
                    state_q <= RD_NUM;
                    read_q  <= 1'b1;
`else
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    error_q <= 1'b0;
`endif
                end
`ifdef DT_MASTER_READBACK_EN
                RD_NUM: begin
                    state_q <= DONE;
                    read_q  <= 1'b0;
                    done_q  <= 1'b1;
                    error_q <= (avm_readdata != {12'd0, num_q});
                end
`endif
                DONE, ERR: begin
                    state_q     <= IDLE;
                    done_q      <= 1'b0;
                    error_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign avm_address   = addr_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
endmodule

// File: tb/tb_digital_tube_avalon_master.sv
// tb/tb_digital_tube_avalon_master.sv - self-checking bench for digital_tube_avalon_master
module tb_digital_tube_avalon_master;
    localparam int TMO = 4;
`ifdef DT_MASTER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_num = '0;
    logic        req_enable = 1'b0;
    logic        busy, done, error;
    logic        avm_address, avm_write, avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;

    always #5 clk = ~clk;

    digital_tube_avalon_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_enable(req_enable),
        .busy(busy), .done(done), .error(error),
        .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] slave_mem [2];
    logic [32:0] wr_log [$];
    int          rd_cnt;
    int          r_done_cyc, r_hold_bad, r_busy_bad;
    logic        r_err, r_ready_before, r_ready_after, r_busy_after, r_strobe_done;

    function automatic logic [19:0] sat(input logic [19:0] v);
        return (int'(v) > 999999) ? 20'd999999 : v;
    endfunction

    // Acts as the display slave: stalls the chosen command, stores writes, answers reads.
    task automatic do_req(input logic [19:0] num, input logic en, input int stall_cmd,
                          input int stall_n, input bit corrupt, input logic [31:0] bad);
        int used;
        int cmd;
        logic prev_wait;
        logic [34:0] prev_bus, cur_bus;
        wr_log.delete();
        rd_cnt = 0; r_done_cyc = -1; r_err = 1'b0; r_hold_bad = 0; r_busy_bad = 0;
        r_strobe_done = 1'b0; used = 0; prev_wait = 1'b0; prev_bus = '0;
        r_ready_before = req_ready;
        req_num = num; req_enable = en; req_valid = 1'b1; avm_waitrequest = 1'b0;
        for (int c = 1; c <= 100 && r_done_cyc < 0; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_num = 20'($urandom); req_enable = 1'($urandom);
            cur_bus = {avm_address, avm_write, avm_read, avm_writedata};
            if (!busy) r_busy_bad++;
            if (done) begin
                r_done_cyc = c; r_err = error; r_strobe_done = avm_write | avm_read;
            end else begin
                if (prev_wait && prev_bus !== cur_bus) r_hold_bad++;
                if (avm_write && avm_read) r_hold_bad++;
                cmd = avm_write ? (avm_address ? 1 : 0) : (avm_read ? 2 : 3);
                avm_waitrequest = (cmd == stall_cmd && used < stall_n);
                if (avm_waitrequest) used++;
                avm_readdata = corrupt ? bad : slave_mem[0];
                if (!avm_waitrequest && avm_write) begin
                    wr_log.push_back({avm_address, avm_writedata});
                    slave_mem[avm_address] = avm_writedata;
                end
                if (!avm_waitrequest && avm_read) rd_cnt++;
                prev_wait = avm_waitrequest && cmd != 3;
                prev_bus = cur_bus;
            end
        end
        avm_waitrequest = 1'b0;
        @(posedge clk); #1;
        r_ready_after = req_ready; r_busy_after = busy;
    endtask

    task automatic test_reset();
        logic [38:0] got, exp;
        exp = {1'b1, 38'd0};
        got = {req_ready, busy, done, error, avm_write, avm_read, avm_address, avm_writedata};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_state: got %h expected %h", got, exp); end
    endtask

    task automatic test_zero_wait();
        do_req(20'd123456, 1'b1, 3, 0, 1'b0, 32'd0);
        n_cmp++; if (r_ready_before !== 1'b1) begin n_bad++; $display("FAIL zw_ready_before: got %b expected 1", r_ready_before); end
        n_cmp++; if (r_done_cyc !== 3 + RB) begin n_bad++; $display("FAIL zw_done_cycle: got %0d expected %0d", r_done_cyc, 3 + RB); end
        n_cmp++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL zw_error: got %b expected 0", r_err); end
        n_cmp++; if (wr_log.size() !== 2) begin n_bad++; $display("FAIL zw_write_count: got %0d expected 2", wr_log.size()); end
        else begin
            n_cmp++; if (wr_log[0] !== {1'b0, 32'h0001E240}) begin n_bad++; $display("FAIL zw_write0: got %h expected %h", wr_log[0], {1'b0, 32'h0001E240}); end
            n_cmp++; if (wr_log[1] !== {1'b1, 32'h1}) begin n_bad++; $display("FAIL zw_write1: got %h expected %h", wr_log[1], {1'b1, 32'h1}); end
        end
        n_cmp++; if (rd_cnt !== RB) begin n_bad++; $display("FAIL zw_reads: got %0d expected %0d", rd_cnt, RB); end
        n_cmp++; if (r_busy_bad !== 0) begin n_bad++; $display("FAIL zw_busy: got %0d idle cycles expected 0", r_busy_bad); end
        n_cmp++; if ({r_ready_after, r_busy_after} !== 2'b10) begin n_bad++; $display("FAIL zw_ready_after: got %b expected 10", {r_ready_after, r_busy_after}); end
    endtask

    task automatic test_saturation();
        logic [19:0] vals [4];
        logic [19:0] want [4];
        vals = '{20'hFFFFF, 20'd1000000, 20'd999999, 20'd999998};
        want = '{20'd999999, 20'd999999, 20'd999999, 20'd999998};
        foreach (vals[i]) begin
            do_req(vals[i], 1'b0, 3, 0, 1'b0, 32'd0);
            n_cmp++;
            if (wr_log.size() < 1 || wr_log[0] !== {1'b0, 12'd0, want[i]}) begin
                n_bad++;
                $display("FAIL sat_%0d: got %h expected %h", i, (wr_log.size() > 0) ? wr_log[0] : 33'h0, {1'b0, 12'd0, want[i]});
            end
        end
    endtask

    task automatic test_back_pressure();
        do_req(20'd42, 1'b1, 1, 3, 1'b0, 32'd0);
        n_cmp++; if (r_done_cyc !== 6 + RB) begin n_bad++; $display("FAIL bp_done_cycle: got %0d expected %0d", r_done_cyc, 6 + RB); end
        n_cmp++; if (r_hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d changes expected 0", r_hold_bad); end
        n_cmp++; if (wr_log.size() !== 2 || wr_log[1] !== {1'b1, 32'h1}) begin n_bad++; $display("FAIL bp_writes: got %0d writes expected 2", wr_log.size()); end
        n_cmp++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL bp_error: got %b expected 0", r_err); end
    endtask

    task automatic test_timeout();
        do_req(20'd77, 1'b1, 0, 1000, 1'b0, 32'd0);
        n_cmp++; if (r_done_cyc !== 1 + TMO + 1) begin n_bad++; $display("FAIL to_done_cycle: got %0d expected %0d", r_done_cyc, TMO + 2); end
        n_cmp++; if (r_err !== 1'b1) begin n_bad++; $display("FAIL to_error: got %b expected 1", r_err); end
        n_cmp++; if (r_strobe_done !== 1'b0) begin n_bad++; $display("FAIL to_strobe_drop: got %b expected 0", r_strobe_done); end
        n_cmp++; if (wr_log.size() !== 0) begin n_bad++; $display("FAIL to_no_writes: got %0d expected 0", wr_log.size()); end
        n_cmp++; if (r_ready_after !== 1'b1) begin n_bad++; $display("FAIL to_ready_after: got %b expected 1", r_ready_after); end
    endtask

`ifdef DT_MASTER_READBACK_EN
    task automatic test_mismatch();
        do_req(20'd8, 1'b1, 3, 0, 1'b1, 32'h7);
        n_cmp++; if ({r_done_cyc == 4, r_err} !== 2'b11) begin n_bad++; $display("FAIL rb_mismatch: got cycle %0d err %b expected cycle 4 err 1", r_done_cyc, r_err); end
        do_req(20'd8, 1'b1, 2, 2, 1'b0, 32'd0);
        n_cmp++; if ({r_done_cyc == 6, r_err} !== 2'b10) begin n_bad++; $display("FAIL rb_stall_match: got cycle %0d err %b expected cycle 6 err 0", r_done_cyc, r_err); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [38:0] got;
        req_num = 20'd4321; req_enable = 1'b1; req_valid = 1'b1; avm_waitrequest = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1; avm_waitrequest = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({avm_write, avm_address} !== 2'b11) begin n_bad++; $display("FAIL rm_pre_state: got %b expected 11", {avm_write, avm_address}); end
        #2 rst_n = 1'b0; #1;
        got = {req_ready, busy, done, error, avm_write, avm_read, avm_address, avm_writedata};
        n_cmp++; if (got !== {1'b1, 38'd0}) begin n_bad++; $display("FAIL rm_async_reset: got %h expected %h", got, {1'b1, 38'd0}); end
        @(posedge clk); #3;
        rst_n = 1'b1; avm_waitrequest = 1'b0;
        do_req(20'd31337, 1'b0, 3, 0, 1'b0, 32'd0);
        n_cmp++;
        if (r_done_cyc !== 3 + RB || wr_log.size() !== 2 || wr_log[0] !== {1'b0, 32'd31337} || wr_log[1] !== {1'b1, 32'd0}) begin
            n_bad++; $display("FAIL rm_after_release: got cycle %0d writes %0d expected cycle %0d writes 2", r_done_cyc, wr_log.size(), 3 + RB);
        end
    endtask

    task automatic test_random();
        logic [19:0] num;
        logic        en;
        int          scmd, sn, exp_cyc;
        bit          corrupt;
        logic [31:0] bad;
        for (int it = 0; it < 24; it++) begin
            num = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(999990, 1048575)) : 20'($urandom);
            en = 1'($urandom);
            scmd = $urandom_range(0, 3);
            sn = $urandom_range(0, 3);
            corrupt = (RB != 0) && ($urandom_range(0, 2) == 0);
            bad = {12'd0, sat(num)} ^ (32'd1 << $urandom_range(0, 31));
            do_req(num, en, scmd, sn, corrupt, bad);
            exp_cyc = 3 + RB + ((scmd == 3 || (scmd == 2 && RB == 0)) ? 0 : sn);
            n_cmp++; if (r_done_cyc !== exp_cyc) begin n_bad++; $display("FAIL rnd%0d_cycle: got %0d expected %0d", it, r_done_cyc, exp_cyc); end
            n_cmp++; if (r_err !== 1'(corrupt)) begin n_bad++; $display("FAIL rnd%0d_error: got %b expected %b", it, r_err, corrupt); end
            n_cmp++;
            if (wr_log.size() !== 2 || wr_log[0] !== {1'b0, 12'd0, sat(num)} || wr_log[1] !== {1'b1, 31'd0, en}) begin
                n_bad++; $display("FAIL rnd%0d_writes: got %0d writes first %h expected %h", it, wr_log.size(),
                                  (wr_log.size() > 0) ? wr_log[0] : 33'h0, {1'b0, 12'd0, sat(num)});
            end
            n_cmp++; if (r_hold_bad !== 0) begin n_bad++; $display("FAIL rnd%0d_hold: got %0d changes expected 0", it, r_hold_bad); end
        end
    endtask

    initial begin
        slave_mem[0] = '0; slave_mem[1] = '0;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_zero_wait();
        test_saturation();
        test_back_pressure();
        test_timeout();
`ifdef DT_MASTER_READBACK_EN
        test_mismatch();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
